// File: rtl/dl_pkg.sv
// Shared types for the download loader: queued write entry, byte-enable codes and request FSM states.
package dl_pkg;

  localparam logic [1:0] DS_BOTH = 2'b11;
  localparam logic [1:0] DS_LO   = 2'b01;
  localparam logic [1:0] DS_HI   = 2'b10;

  typedef struct packed {
    logic [22:0] addr;
    logic [1:0]  ds;
    logic [15:0] data;
  } dl_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dl_state_e;

  function automatic dl_entry_t mk_entry(input logic [22:0] addr, input logic [1:0] ds,
                                         input logic [7:0] hi, input logic [7:0] lo);
    dl_entry_t e;
    e.addr = addr;
    e.ds   = ds;
    e.data = {hi, lo};
    return e;
  endfunction

endpackage

// File: rtl/dl_fifo.sv
// Registered FIFO of write entries; a push alongside a pop is accepted even when full,
// a push while full without a pop is ignored (the caller flags it).
module dl_fifo
  import dl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      init_n,
  input  logic      push,
  input  dl_entry_t din,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output dl_entry_t head
);

  localparam int unsigned PW = $clog2(DEPTH);

  dl_entry_t       mem_q [DEPTH];
  logic [PW:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]     rd_ptr_q, rd_ptr_d;
  logic            do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers define which slots are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= din;
  end

endmodule

// File: rtl/sdram_dl_loader.sv
// Packs the byte-wide ROM download stream into 16-bit writes with byte enables, queues them,
// and issues them to the SDRAM controller over its toggle request/acknowledge port.
module sdram_dl_loader
  import dl_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 23,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [7:0]        INDEX      = 8'd0,
  parameter logic [ADDR_W-1:0] BASE       = '0
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic        ioctl_downl,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic        port1_we,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  logic              dl_hit, dl_q, dl_rise, dl_fall, accept;
  logic [ADDR_W-1:0] waddr;
  logic              unused_addr_bits;

  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [7:0]        pend_lo_q, pend_lo_d;

  logic              push_vld;
  dl_entry_t         push_dat;
  logic              fifo_full, fifo_empty, fifo_pop;
  dl_entry_t         fifo_head;

  dl_state_e         state_q, state_d;
  logic              issue;
  logic              req_q, req_d;
  logic [22:0]       a_q, a_d;
  logic [1:0]        ds_q, ds_d;
  logic [15:0]       d_q, d_d;

  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              seen_q, seen_d;

  assign dl_hit  = ioctl_downl && (ioctl_index == INDEX);
  assign accept  = ioctl_wr && dl_hit;
  assign dl_rise = dl_hit && !dl_q;
  assign dl_fall = !dl_hit && dl_q;
  assign waddr   = BASE + ioctl_addr[ADDR_W:1];
  assign unused_addr_bits = ^ioctl_addr;

  // Byte packing: at most one word is produced per cycle.
  always_comb begin
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_lo_d   = pend_lo_q;
    push_vld    = 1'b0;
    push_dat    = '0;
    if (dl_fall && pend_q) begin
      push_vld = 1'b1;
      push_dat = mk_entry(23'(pend_addr_q), DS_LO, 8'h00, pend_lo_q);
      pend_d   = 1'b0;
    end else if (accept) begin
      if (!ioctl_addr[0]) begin
        if (pend_q) begin
          push_vld = 1'b1;
          push_dat = mk_entry(23'(pend_addr_q), DS_LO, 8'h00, pend_lo_q);
        end
        pend_d      = 1'b1;
        pend_addr_d = waddr;
        pend_lo_d   = ioctl_dout;
      end else if (pend_q && (pend_addr_q == waddr)) begin
        push_vld = 1'b1;
        push_dat = mk_entry(23'(waddr), DS_BOTH, ioctl_dout, pend_lo_q);
        pend_d   = 1'b0;
      end else begin
        push_vld = 1'b1;
        push_dat = mk_entry(23'(waddr), DS_HI, ioctl_dout, 8'h00);
      end
    end
  end

  dl_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .init_n (init_n),
    .push   (push_vld),
    .din    (push_dat),
    .pop    (fifo_pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

  // The head is copied into the port registers at issue, so its slot frees immediately and
  // the queue holds FIFO_DEPTH further words behind the outstanding request.
  assign issue    = (state_q == IDLE) && !fifo_empty;
  assign fifo_pop = issue;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = WAIT;
      WAIT:    if (port1_ack == req_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d = req_q;
    a_d   = a_q;
    ds_d  = ds_q;
    d_d   = d_q;
    if (issue) begin
      req_d = ~req_q;
      a_d   = fifo_head.addr;
      ds_d  = fifo_head.ds;
      d_d   = fifo_head.data;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (dl_rise) ovf_d = 1'b0;
    if (push_vld && fifo_full && !fifo_pop) ovf_d = 1'b1;
    busy_d = dl_hit || !fifo_empty || push_vld || pend_q || (state_d == WAIT);
    done_d = seen_q && !dl_hit && fifo_empty && !push_vld && !pend_q && (state_q == IDLE);
    seen_d = (seen_q && !done_d) || dl_hit;
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      a_q         <= '0;
      ds_q        <= '0;
      d_q         <= '0;
      dl_q        <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_lo_q   <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      seen_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      a_q         <= a_d;
      ds_q        <= ds_d;
      d_q         <= d_d;
      dl_q        <= dl_hit;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_lo_q   <= pend_lo_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      seen_q      <= seen_d;
    end
  end

  assign port1_req = req_q;
  assign port1_we  = 1'b1;
  assign port1_a   = a_q;
  assign port1_ds  = ds_q;
  assign port1_d   = d_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_sdram_dl_loader.sv
// Randomized scoreboard bench for sdram_dl_loader with a behavioural controller on port1.
module tb_sdram_dl_loader;

  localparam int          DEPTH = 4;
  localparam logic [22:0] BASE0 = 23'd0;
  localparam logic [22:0] BASE1 = 23'h7FFFFF;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        init_n, ioctl_downl, ioctl_wr, wrap_en;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;

  logic        port1_req, port1_we, busy, done, overflow;
  logic        port1_ack = 1'b0;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;

  logic        w_req, w_we, w_busy, w_done, w_ovf;
  logic        w_ack = 1'b0;
  logic [22:0] w_a;
  logic [1:0]  w_ds;
  logic [15:0] w_d;

  sdram_dl_loader #(.ADDR_W(23), .FIFO_DEPTH(DEPTH), .INDEX(8'd0), .BASE(BASE0)) dut (
    .clk(clk), .init_n(init_n), .ioctl_downl(ioctl_downl), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_we(port1_we), .port1_a(port1_a),
    .port1_ds(port1_ds), .port1_d(port1_d), .busy(busy), .done(done), .overflow(overflow)
  );

  sdram_dl_loader #(.ADDR_W(23), .FIFO_DEPTH(DEPTH), .INDEX(8'd0), .BASE(BASE1)) u_wrap (
    .clk(clk), .init_n(init_n), .ioctl_downl(ioctl_downl), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr & wrap_en), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .port1_req(w_req), .port1_ack(w_ack), .port1_we(w_we), .port1_a(w_a),
    .port1_ds(w_ds), .port1_d(w_d), .busy(w_busy), .done(w_done), .overflow(w_ovf)
  );

  typedef struct {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } exp_t;

  exp_t exp_q[$];
  exp_t wexp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Controller / monitor state
  bit   ack_hold = 1'b0;
  int   ack_cnt = 0;
  logic prev_req = 1'b0;
  logic w_prev = 1'b0;
  exp_t snap, e, we_;
  bit   unstable = 1'b0;
  bit   busy_seen = 1'b0;
  int   req_cnt = 0;
  int   wreq_cnt = 0;
  int   done_cnt = 0;

  // Reference model state
  bit          m_pend = 1'b0;
  logic [22:0] m_paddr;
  logic [7:0]  m_plo;
  int          held = 0;
  bit          ov_exp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [22:0] word_addr(input logic [22:0] base, input logic [24:0] baddr);
    longint w;
    w = (longint'(base) + longint'(baddr / 2)) % (longint'(1) << 23);
    return 23'(w);
  endfunction

  // With acks withheld the loader can hold one outstanding word plus a full queue.
  task automatic model_push(input logic [22:0] a, input logic [1:0] ds, input logic [15:0] d);
    exp_t x;
    if (ack_hold && held >= 1 + DEPTH) begin
      ov_exp = 1'b1;
    end else begin
      x.a = a; x.ds = ds; x.d = d;
      exp_q.push_back(x);
      if (ack_hold) held++;
    end
  endtask

  task automatic model_byte(input logic [24:0] addr, input logic [7:0] data);
    logic [22:0] w;
    w = word_addr(BASE0, addr);
    if (addr % 2 == 0) begin
      if (m_pend) model_push(m_paddr, 2'b01, {8'h00, m_plo});
      m_pend = 1'b1; m_paddr = w; m_plo = data;
    end else if (m_pend && m_paddr == w) begin
      model_push(w, 2'b11, {data, m_plo});
      m_pend = 1'b0;
    end else begin
      model_push(w, 2'b10, {data, 8'h00});
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [24:0] addr, input logic [7:0] data, input int gap);
    ioctl_addr = addr; ioctl_dout = data; ioctl_wr = 1'b1;
    tick(1);
    ioctl_wr = 1'b0;
    if (ioctl_downl && ioctl_index == 8'd0) model_byte(addr, data);
    if (gap > 1) tick(gap - 1);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx; ioctl_downl = 1'b1;
    tick(1);
  endtask

  task automatic end_dl();
    ioctl_downl = 1'b0;
    if (ioctl_index == 8'd0 && m_pend) model_push(m_paddr, 2'b01, {8'h00, m_plo});
    m_pend = 1'b0;
    tick(1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy || port1_req !== port1_ack) && n < 800) begin
      @(negedge clk);
      n++;
    end
    if (n >= 800) begin
      checks++; failures++;
      $display("FAIL %s_drain pending=%0d busy=%b required pending=0 busy=0", name, exp_q.size(), busy);
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor plus controller model: acknowledges 6 cycles after each request toggle.
  always @(negedge clk) begin
    if (!init_n) begin
      prev_req = 1'b0; w_prev = 1'b0; ack_cnt = 0;
      port1_ack = 1'b0; w_ack = 1'b0;
    end else begin
      if (port1_req !== prev_req) begin
        req_cnt++;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_req a=%h ds=%b d=%h required=no request", port1_a, port1_ds, port1_d);
        end else begin
          e = exp_q.pop_front();
          chk("req_a", 32'(port1_a), 32'(e.a));
          chk("req_ds", 32'(port1_ds), 32'(e.ds));
          chk("req_d", 32'(port1_d), 32'(e.d));
        end
        snap.a = port1_a; snap.ds = port1_ds; snap.d = port1_d;
        unstable = 1'b0; prev_req = port1_req; ack_cnt = 0;
      end else if (port1_req !== port1_ack) begin
        if (port1_a !== snap.a || port1_ds !== snap.ds || port1_d !== snap.d) unstable = 1'b1;
      end
      if (port1_req !== port1_ack && !ack_hold) begin
        ack_cnt++;
        if (ack_cnt >= 6) begin
          chk("hold_stable", 32'(unstable), 32'd0);
          port1_ack = port1_req;
        end
      end
      if (done) done_cnt++;
      if (busy) busy_seen = 1'b1;
      if (w_req !== w_prev) begin
        wreq_cnt++;
        if (wexp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL wrap_unexpected_req a=%h required=no request", w_a);
        end else begin
          we_ = wexp_q.pop_front();
          chk("wrap_a", 32'(w_a), 32'(we_.a));
          chk("wrap_ds", 32'(w_ds), 32'(we_.ds));
          chk("wrap_d", 32'(w_d), 32'(we_.d));
        end
        w_prev = w_req;
      end
      if (w_req !== w_ack) w_ack = w_req;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, d0;
    logic [24:0] p;
    exp_t x;
    init_n = 1'b0; ioctl_downl = 1'b0; ioctl_wr = 1'b0; ioctl_index = 8'd0;
    ioctl_addr = '0; ioctl_dout = '0; wrap_en = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_req", 32'(port1_req), 32'd0);
    chk("rst_a", 32'(port1_a), 32'd0);
    chk("rst_ds", 32'(port1_ds), 32'd0);
    chk("rst_d", 32'(port1_d), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("we_const", 32'(port1_we), 32'd1);
    tick(1);
    init_n = 1'b1;
    tick(2);

    // Single full word
    d0 = done_cnt;
    start_dl(8'd0);
    send_byte(25'd0, 8'h11, 3);
    send_byte(25'd1, 8'h22, 3);
    end_dl();
    wait_drain("pair");
    chk("pair_done", 32'(done_cnt - d0), 32'd1);

    // Odd-length download: trailing low byte flushed at the end
    d0 = done_cnt;
    start_dl(8'd0);
    send_byte(25'd0, 8'hAA, 3);
    send_byte(25'd1, 8'hBB, 3);
    send_byte(25'd2, 8'hCC, 3);
    end_dl();
    wait_drain("odd");
    chk("odd_done", 32'(done_cnt - d0), 32'd1);

    // Other download index is ignored
    r0 = req_cnt; d0 = done_cnt; busy_seen = 1'b0;
    start_dl(8'd1);
    send_byte(25'd0, 8'h55, 3);
    send_byte(25'd1, 8'h66, 3);
    end_dl();
    tick(12);
    chk("idx_req", 32'(req_cnt - r0), 32'd0);
    chk("idx_busy", 32'(busy_seen), 32'd0);
    chk("idx_done", 32'(done_cnt - d0), 32'd0);

    // Randomized stream with skips and unpaired bytes
    d0 = done_cnt;
    start_dl(8'd0);
    p = 25'($urandom_range(0, 200));
    for (int i = 0; i < 40; i++) begin
      send_byte(p, 8'($urandom), $urandom_range(9, 12));
      p = p + (($urandom_range(0, 3) == 0) ? 25'($urandom_range(2, 5)) : 25'd1);
    end
    end_dl();
    wait_drain("rand");
    chk("rand_ovf", 32'(overflow), 32'd0);
    chk("rand_done", 32'(done_cnt - d0), 32'd1);

    // Acks withheld: queue fills, excess words dropped
    r0 = req_cnt; ack_hold = 1'b1; held = 0; ov_exp = 1'b0;
    start_dl(8'd0);
    for (int i = 0; i < 12; i++) begin
      send_byte(25'(2 * i), 8'($urandom), 2);
      send_byte(25'(2 * i + 1), 8'($urandom), 2);
    end
    end_dl();
    tick(4);
    chk("ovf_flag", 32'(overflow), 32'(ov_exp));
    chk("ovf_outstanding", 32'(req_cnt - r0), 32'd1);
    ack_hold = 1'b0;
    wait_drain("ovf");
    chk("ovf_total_reqs", 32'(req_cnt - r0), 32'(1 + DEPTH));
    chk("ovf_sticky", 32'(overflow), 32'd1);
    start_dl(8'd0);
    tick(2);
    chk("ovf_clear", 32'(overflow), 32'd0);
    end_dl();
    tick(3);

    // Reset while a request is outstanding
    ack_hold = 1'b1; held = 0;
    start_dl(8'd0);
    send_byte(25'd8, 8'h01, 3);
    send_byte(25'd9, 8'h02, 3);
    send_byte(25'd10, 8'h03, 3);
    send_byte(25'd11, 8'h04, 3);
    end_dl();
    tick(3);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_req", 32'(port1_req !== port1_ack), 32'd1);
    init_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", 32'(port1_req), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    m_pend = 1'b0;
    tick(1);
    init_n = 1'b1; ack_hold = 1'b0;
    tick(2);
    r0 = req_cnt; d0 = done_cnt;
    start_dl(8'd0);
    send_byte(25'd20, 8'h77, 3);
    send_byte(25'd21, 8'h88, 3);
    end_dl();
    wait_drain("post_rst");
    chk("post_rst_reqs", 32'(req_cnt - r0), 32'd1);
    chk("post_rst_done", 32'(done_cnt - d0), 32'd1);

    // Address wrap with BASE at the top of the word space
    wrap_en = 1'b1;
    x.a = word_addr(BASE1, 25'd2); x.ds = 2'b11; x.d = 16'h4433;
    wexp_q.push_back(x);
    r0 = wreq_cnt;
    start_dl(8'd0);
    send_byte(25'd2, 8'h33, 3);
    send_byte(25'd3, 8'h44, 3);
    end_dl();
    wait_drain("wrap");
    tick(5);
    chk("wrap_reqs", 32'(wreq_cnt - r0), 32'd1);
    chk("wrap_addr_zero", 32'(x.a), 32'd0);
    wrap_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
